cvxif_copro_responder: RTL

CVXIF_COPRO_RESPONDER -- requirements
Module: cvxif_copro_responder

---
 rtl/cvxif_copro_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF style coprocessor responder. It decodes custom-3 ops, holds them in an in-order
// buffer until commit, and returns results in allocation order. Define CVXIF_COPRO_MULTICYCLE_EN to add CUS_MADD.
module cvxif_copro_responder #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [2*XLEN-1:0]   issue_rs_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_CUSTOM3 = 7'h7B;
  localparam logic [2:0] F3_ADD      = 3'b000;
  localparam logic [2:0] F3_NOP      = 3'b001;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
  localparam logic [2:0] F3_MADD     = 3'b010;
`endif

  localparam logic [2:0] S_FREE        = 3'd0;
  localparam logic [2:0] S_WAIT_COMMIT = 3'd1;
  localparam logic [2:0] S_EXEC        = 3'd2;
  localparam logic [2:0] S_DONE        = 3'd3;
  localparam logic [2:0] S_KILLED      = 3'd4;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            is_add;
  logic            is_nop;
  logic            is_madd;
  logic            ops_ok;
  logic [XLEN-1:0] issue_result;
  logic            unused_instr_bits;

  assign opcode            = issue_instr_i[6:0];
  assign rd                = issue_instr_i[11:7];
  assign funct3            = issue_instr_i[14:12];
  assign rs1               = issue_rs_i[XLEN-1:0];
  assign rs2               = issue_rs_i[2*XLEN-1:XLEN];
  assign unused_instr_bits = ^issue_instr_i[31:15];

  // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
  always_comb begin
    is_add  = (opcode == OPC_CUSTOM3) && (funct3 == F3_ADD);
    is_nop  = (opcode == OPC_CUSTOM3) && (funct3 == F3_NOP);
`ifdef CVXIF_COPRO_MULTICYCLE_EN
    is_madd = (opcode == OPC_CUSTOM3) && (funct3 == F3_MADD);
`else
    is_madd = 1'b0;
`endif
    // NOP reads no operands, so its rs_valid bits are don't-care.
    ops_ok            = (is_add || is_madd) ? (&issue_rs_valid_i) : is_nop;
    issue_accept_o    = issue_valid_i && ops_ok;
    issue_writeback_o = issue_valid_i && ops_ok && !is_nop;
    issue_result      = '0;
    if (is_add)       issue_result = rs1 + rs2;
    else if (is_madd) issue_result = rs1 + rs2 + rs1;
  end

  logic [2:0]          ent_state [DEPTH];
  logic [ID_WIDTH-1:0] ent_id    [DEPTH];
  logic [XLEN-1:0]     ent_data  [DEPTH];
  logic [4:0]          ent_rd    [DEPTH];
  logic                ent_we    [DEPTH];
`ifdef CVXIF_COPRO_MULTICYCLE_EN
  logic                ent_multi [DEPTH];
  logic [2:0]          ent_cnt   [DEPTH];
`endif

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [2:0]       head_state;
  logic             alloc;
  logic             free_head;

  assign issue_ready_o  = (count < CNT_W'(DEPTH));
  assign alloc          = issue_accept_o && issue_ready_o;
  assign head_state     = ent_state[head];
  assign result_valid_o = (head_state == S_DONE);
  // A killed head retires silently; a done head retires on the result handshake.
  assign free_head      = (result_valid_o && result_ready_i) || (head_state == S_KILLED);

  // NOTE: payload fields are only ever read through a non-FREE state, so only the state array needs reset.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      ent_id[tail]    <= issue_id_i;
      ent_data[tail]  <= issue_result;
      ent_rd[tail]    <= rd;
      ent_we[tail]    <= !is_nop;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
      ent_multi[tail] <= is_madd;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_state[i] <= S_FREE;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
        ent_cnt[i]   <= '0;
`endif
      end
    end else begin
      if (alloc)     tail <= tail + PTR_W'(1);
      if (free_head) head <= head + PTR_W'(1);
      count <= count + CNT_W'(alloc) - CNT_W'(free_head);

      for (int i = 0; i < DEPTH; i++) begin
        case (ent_state[i])
          S_FREE: begin
            if (alloc && (tail == PTR_W'(i))) ent_state[i] <= S_WAIT_COMMIT;
          end
          S_WAIT_COMMIT: begin
            if (commit_valid_i && (commit_id_i == ent_id[i])) begin
              if (commit_kill_i) begin
                ent_state[i] <= S_KILLED;
              end else begin
                ent_state[i] <= S_EXEC;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
                // Loaded with 3 so the entry spends exactly four cycles in EXEC.
                ent_cnt[i]   <= ent_multi[i] ? 3'd3 : 3'd0;
`endif
              end
            end
          end
          S_EXEC: begin
`ifdef CVXIF_COPRO_MULTICYCLE_EN
            if (ent_cnt[i] == 3'd0) ent_state[i] <= S_DONE;
            else                    ent_cnt[i]   <= ent_cnt[i] - 3'd1;
`else
            ent_state[i] <= S_DONE;
`endif
          end
          S_DONE, S_KILLED: begin
            if (free_head && (head == PTR_W'(i))) ent_state[i] <= S_FREE;
          end
          default: ent_state[i] <= S_FREE;
        endcase
      end
    end
  end

  always_comb begin
    result_id_o   = '0;
    result_data_o = '0;
    result_rd_o   = '0;
    result_we_o   = 1'b0;
    if (result_valid_o) begin
      result_id_o   = ent_id[head];
      result_data_o = ent_data[head];
      result_rd_o   = ent_rd[head];
      result_we_o   = ent_we[head];
    end
  end

endmodule
